// File: rtl/clock_setter.sv
// clock_setter: button-driven edit FSM that buffers time/date/alarm values and commits them with one-cycle strobes
module clock_setter #(
  parameter int EDIT_TIMEOUT = 1_000_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [16:0] time_cur,
  input  logic [20:0] date_cur,
  output logic [16:0] time_out,
  output logic        time_ow,
  output logic [20:0] date_out,
  output logic        date_ow,
  output logic [10:0] alarm_out,
  output logic        alarm_set,
  output logic [1:0]  mode,
  output logic [1:0]  field
);
  typedef enum logic [1:0] {IDLE = 2'd0, EDIT_TIME = 2'd1, EDIT_DATE = 2'd2, EDIT_ALRM = 2'd3} state_t;
  localparam int CW = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(EDIT_TIMEOUT);
  state_t state_q, state_d;
  logic [1:0] field_q, field_d, last;
  logic [16:0] time_q, time_d;
  logic [20:0] date_q, date_d;
  logic [10:0] alarm_q, alarm_d;
  logic time_ow_q, time_ow_d, date_ow_q, date_ow_d, alarm_set_q, alarm_set_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] sel_v, sel_lo, sel_hi, stepped, yr_n;
  logic [4:0] hour_src, day_n, lim;
  logic [5:0] min_src;
  logic [3:0] mon_n;
  logic unused_sec;
  assign unused_sec = ^time_cur[5:0];
  function automatic logic [11:0] step(input logic [11:0] v, input logic [11:0] lo, input logic [11:0] hi, input logic up);
    return up ? (v >= hi ? lo : v + 12'd1) : (v <= lo ? hi : v - 12'd1);
  endfunction
  function automatic logic [4:0] dim(input logic [3:0] m, input logic [11:0] y);
    logic leap;
    leap = y[1:0] == 2'd0 && (y % 12'd100 != 12'd0 || y % 12'd400 == 12'd0);
    return m == 4'd2 ? (leap ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    time_d      = time_q;
    date_d      = date_q;
    alarm_d     = alarm_q;
    time_ow_d   = 1'b0;
    date_ow_d   = 1'b0;
    alarm_set_d = 1'b0;
    cnt_d       = '0;
    last        = state_q == EDIT_DATE ? 2'd2 : 2'd1;
    hour_src    = state_q == EDIT_ALRM ? alarm_q[10:6] : time_q[16:12];
    min_src     = state_q == EDIT_ALRM ? alarm_q[5:0] : time_q[11:6];
    sel_v       = state_q == EDIT_DATE ?
                  (field_q == 2'd0 ? date_q[11:0] : field_q == 2'd1 ? {8'd0, date_q[15:12]} : {7'd0, date_q[20:16]}) :
                  (field_q == 2'd0 ? {7'd0, hour_src} : {6'd0, min_src});
    sel_lo      = state_q == EDIT_DATE && field_q != 2'd0 ? 12'd1 : 12'd0;
    sel_hi      = state_q == EDIT_DATE ?
                  (field_q == 2'd0 ? 12'd4095 : field_q == 2'd1 ? 12'd12 : {7'd0, dim(date_q[15:12], date_q[11:0])}) :
                  (field_q == 2'd0 ? 12'd23 : 12'd59);
    stepped     = step(sel_v, sel_lo, sel_hi, btn_up);
    yr_n        = field_q == 2'd0 ? stepped : date_q[11:0];
    mon_n       = field_q == 2'd1 ? stepped[3:0] : date_q[15:12];
    lim         = dim(mon_n, yr_n);
    day_n       = field_q == 2'd2 ? stepped[4:0] : (date_q[20:16] > lim ? lim : date_q[20:16]);
    if (state_q == IDLE) begin
      if (btn_mode) begin
        state_d = EDIT_TIME;
        field_d = 2'd0;
        time_d  = {time_cur[16:6], 6'd0};
      end
    end else if (btn_mode) begin
      state_d = state_q == EDIT_TIME ? EDIT_DATE : state_q == EDIT_DATE ? EDIT_ALRM : IDLE;
      field_d = 2'd0;
      date_d  = state_q == EDIT_TIME ? date_cur : date_q;
    end else if (btn_next) begin
      if (field_q == last) begin
        state_d     = IDLE;
        field_d     = 2'd0;
        time_ow_d   = state_q == EDIT_TIME;
        date_ow_d   = state_q == EDIT_DATE;
        alarm_set_d = state_q == EDIT_ALRM;
      end else begin
        field_d = field_q + 2'd1;
      end
    end else if (btn_up || btn_down) begin
      time_d  = state_q != EDIT_TIME ? time_q :
                field_q == 2'd0 ? {stepped[4:0], time_q[11:0]} : {time_q[16:12], stepped[5:0], time_q[5:0]};
      alarm_d = state_q != EDIT_ALRM ? alarm_q :
                field_q == 2'd0 ? {stepped[4:0], alarm_q[5:0]} : {alarm_q[10:6], stepped[5:0]};
      date_d  = state_q == EDIT_DATE ? {day_n, mon_n, yr_n} : date_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == LIMIT) begin
        state_d = IDLE;
        field_d = 2'd0;
        cnt_d   = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      field_q     <= 2'd0;
      time_q      <= 17'd0;
      date_q      <= {5'd1, 4'd1, 12'd0};
      alarm_q     <= 11'd0;
      time_ow_q   <= 1'b0;
      date_ow_q   <= 1'b0;
      alarm_set_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      time_q      <= time_d;
      date_q      <= date_d;
      alarm_q     <= alarm_d;
      time_ow_q   <= time_ow_d;
      date_ow_q   <= date_ow_d;
      alarm_set_q <= alarm_set_d;
      cnt_q       <= cnt_d;
    end
  end
  assign mode      = state_q;
  assign field     = field_q;
  assign time_out  = time_q;
  assign date_out  = date_q;
  assign alarm_out = alarm_q;
  assign time_ow   = time_ow_q;
  assign date_ow   = date_ow_q;
  assign alarm_set = alarm_set_q;
endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: directed and randomized self-checking bench for clock_setter
module tb_clock_setter;
  localparam int TO = 16;
  localparam logic [3:0] M = 4'b1000, N = 4'b0100, U = 4'b0010, D = 4'b0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [16:0] time_cur = '0, time_out;
  logic [20:0] date_cur = '0, date_out;
  logic [10:0] alarm_out;
  logic time_ow, date_ow, alarm_set;
  logic [1:0] mode, field;
  int checks = 0, errors = 0;
  int m_mode, m_field, th, tm, ah, am, dd, dmo, dy, idle_n;
  bit e_tow, e_dow, e_as;
  clock_setter #(.EDIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .time_cur(time_cur), .date_cur(date_cur), .time_out(time_out), .time_ow(time_ow),
    .date_out(date_out), .date_ow(date_ow), .alarm_out(alarm_out), .alarm_set(alarm_set),
    .mode(mode), .field(field)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] tv(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction
  function automatic logic [20:0] dv(input int d, input int mo, input int y);
    return {5'(d), 4'(mo), 12'(y)};
  endfunction
  function automatic int dim_f(input int mo, input int y);
    int days [12];
    bit leap;
    days = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    leap = (y % 4 == 0) && (y % 100 != 0 || y % 400 == 0);
    return (mo == 2 && leap) ? 29 : days[mo-1];
  endfunction
  function automatic int wrap(input int v, input int lo, input int hi, input int d);
    int n;
    n = hi - lo + 1;
    return lo + (((v - lo + d) % n) + n) % n;
  endfunction
  task automatic model_reset;
    m_mode = 0; m_field = 0; th = 0; tm = 0; ah = 0; am = 0;
    dd = 1; dmo = 1; dy = 0; idle_n = 0;
    e_tow = 0; e_dow = 0; e_as = 0;
  endtask
  task automatic model_edge(input logic [3:0] b, input logic [16:0] tc, input logic [20:0] dc);
    int last, d;
    e_tow = 0; e_dow = 0; e_as = 0;
    last = (m_mode == 2) ? 2 : 1;
    d = b[1] ? 1 : -1;
    if (b == 4'd0) begin
      if (m_mode != 0) begin
        idle_n++;
        if (idle_n == TO) begin
          m_mode = 0; m_field = 0; idle_n = 0;
        end
      end
    end else begin
      idle_n = 0;
      if (b[3]) begin
        if (m_mode == 0) begin th = int'(tc[16:12]); tm = int'(tc[11:6]); end
        if (m_mode == 1) begin dd = int'(dc[20:16]); dmo = int'(dc[15:12]); dy = int'(dc[11:0]); end
        m_mode = (m_mode + 1) % 4;
        m_field = 0;
      end else if (m_mode != 0) begin
        if (b[2]) begin
          if (m_field == last) begin
            e_tow = m_mode == 1; e_dow = m_mode == 2; e_as = m_mode == 3;
            m_mode = 0; m_field = 0;
          end else m_field++;
        end else if (m_mode == 1) begin
          if (m_field == 0) th = wrap(th, 0, 23, d); else tm = wrap(tm, 0, 59, d);
        end else if (m_mode == 3) begin
          if (m_field == 0) ah = wrap(ah, 0, 23, d); else am = wrap(am, 0, 59, d);
        end else begin
          if (m_field == 0) dy = wrap(dy, 0, 4095, d);
          else if (m_field == 1) dmo = wrap(dmo, 1, 12, d);
          else dd = wrap(dd, 1, dim_f(dmo, dy), d);
          if (dd > dim_f(dmo, dy)) dd = dim_f(dmo, dy);
        end
      end
    end
  endtask
  task automatic press(input logic [3:0] b);
    {btn_mode, btn_next, btn_up, btn_down} = b;
    @(negedge clk);
    {btn_mode, btn_next, btn_up, btn_down} = 4'd0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset;
    @(negedge clk);
    do_reset();
    checks++;
    if (mode !== 2'd0 || field !== 2'd0) begin
      errors++; $display("FAIL reset_state mode=%0d field=%0d expected 0 0", mode, field);
    end
    checks++;
    if (time_out !== 17'd0 || alarm_out !== 11'd0 || date_out !== dv(1, 1, 0)) begin
      errors++; $display("FAIL reset_buffers time=%h alarm=%h date=%h expected 0 0 %h", time_out, alarm_out, date_out, dv(1, 1, 0));
    end
    checks++;
    if ({time_ow, date_ow, alarm_set} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got=%b expected 000", {time_ow, date_ow, alarm_set});
    end
  endtask
  task automatic test_time_edit;
    time_cur = tv(12, 34, 56);
    press(M);
    checks++;
    if (mode !== 2'd1 || field !== 2'd0 || time_out !== tv(12, 34, 0)) begin
      errors++; $display("FAIL time_load mode=%0d field=%0d time=%h expected 1 0 %h", mode, field, time_out, tv(12, 34, 0));
    end
    press(U); press(N); press(D);
    checks++;
    if (field !== 2'd1 || time_out !== tv(13, 33, 0) || time_ow !== 1'b0) begin
      errors++; $display("FAIL time_adjust field=%0d time=%h ow=%b expected 1 %h 0", field, time_out, time_ow, tv(13, 33, 0));
    end
    press(N);
    checks++;
    if ({time_ow, date_ow, alarm_set} !== 3'b100 || time_out !== tv(13, 33, 0) || mode !== 2'd0 || field !== 2'd0) begin
      errors++; $display("FAIL time_commit strobes=%b time=%h mode=%0d field=%0d expected 100 %h 0 0",
                         {time_ow, date_ow, alarm_set}, time_out, mode, field, tv(13, 33, 0));
    end
    @(negedge clk);
    checks++;
    if (time_ow !== 1'b0 || time_out !== tv(13, 33, 0)) begin
      errors++; $display("FAIL time_strobe_len ow=%b time=%h expected 0 %h", time_ow, time_out, tv(13, 33, 0));
    end
  endtask
  task automatic test_date_clamp;
    for (int k = 0; k < 2; k++) begin
      int y, ed;
      y = k ? 2024 : 2023;
      ed = k ? 29 : 28;
      date_cur = dv(31, 3, y);
      press(M); press(M);
      checks++;
      if (mode !== 2'd2 || date_out !== dv(31, 3, y)) begin
        errors++; $display("FAIL date_load y=%0d mode=%0d date=%h expected 2 %h", y, mode, date_out, dv(31, 3, y));
      end
      press(N); press(D);
      checks++;
      if (date_out !== dv(ed, 2, y)) begin
        errors++; $display("FAIL date_clamp y=%0d date=%h expected %h", y, date_out, dv(ed, 2, y));
      end
      press(N); press(N);
      checks++;
      if ({time_ow, date_ow, alarm_set} !== 3'b010 || date_out !== dv(ed, 2, y) || mode !== 2'd0) begin
        errors++; $display("FAIL date_commit y=%0d strobes=%b date=%h mode=%0d expected 010 %h 0",
                           y, {time_ow, date_ow, alarm_set}, date_out, mode, dv(ed, 2, y));
      end
    end
  endtask
  task automatic test_wraps;
    time_cur = tv(23, 0, 7);
    press(M); press(U);
    checks++;
    if (time_out !== tv(0, 0, 0)) begin
      errors++; $display("FAIL wrap_hour time=%h expected %h", time_out, tv(0, 0, 0));
    end
    press(N); press(D);
    checks++;
    if (time_out !== tv(0, 59, 0)) begin
      errors++; $display("FAIL wrap_min time=%h expected %h", time_out, tv(0, 59, 0));
    end
    date_cur = dv(1, 12, 0);
    press(M); press(D);
    checks++;
    if (date_out !== dv(1, 12, 4095)) begin
      errors++; $display("FAIL wrap_year date=%h expected %h", date_out, dv(1, 12, 4095));
    end
    press(N); press(U);
    checks++;
    if (date_out !== dv(1, 1, 4095)) begin
      errors++; $display("FAIL wrap_month date=%h expected %h", date_out, dv(1, 1, 4095));
    end
    press(M); press(M);
    checks++;
    if (mode !== 2'd0 || {time_ow, date_ow, alarm_set} !== 3'b000) begin
      errors++; $display("FAIL abort mode=%0d strobes=%b expected 0 000", mode, {time_ow, date_ow, alarm_set});
    end
    date_cur = dv(1, 4, 2023);
    press(M); press(M); press(N); press(N); press(D);
    checks++;
    if (date_out !== dv(30, 4, 2023)) begin
      errors++; $display("FAIL wrap_day date=%h expected %h", date_out, dv(30, 4, 2023));
    end
    press(M); press(M);
  endtask
  task automatic test_timeout;
    bit seen;
    seen = 0;
    time_cur = tv(10, 20, 0);
    press(M); press(U);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      seen |= time_ow;
    end
    checks++;
    if (mode !== 2'd1) begin
      errors++; $display("FAIL timeout_early mode=%0d expected 1", mode);
    end
    @(negedge clk);
    checks++;
    if (mode !== 2'd0) begin
      errors++; $display("FAIL timeout_abort mode=%0d expected 0", mode);
    end
    repeat (3) begin
      @(negedge clk);
      seen |= time_ow;
    end
    checks++;
    if (seen !== 1'b0 || time_out !== tv(11, 20, 0)) begin
      errors++; $display("FAIL timeout_nostrobe seen=%b time=%h expected 0 %h", seen, time_out, tv(11, 20, 0));
    end
    press(M);
    repeat (10) @(negedge clk);
    press(U);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (mode !== 2'd1) begin
      errors++; $display("FAIL timeout_restart mode=%0d expected 1", mode);
    end
    @(negedge clk);
    checks++;
    if (mode !== 2'd0) begin
      errors++; $display("FAIL timeout_abort2 mode=%0d expected 0", mode);
    end
  endtask
  task automatic test_priority_and_rst;
    bit seen;
    seen = 0;
    time_cur = tv(5, 6, 0);
    press(M); press(N); press(N | U);
    checks++;
    if ({time_ow, date_ow, alarm_set} !== 3'b100 || time_out !== tv(5, 6, 0) || mode !== 2'd0) begin
      errors++; $display("FAIL prio_next_up strobes=%b time=%h mode=%0d expected 100 %h 0",
                         {time_ow, date_ow, alarm_set}, time_out, mode, tv(5, 6, 0));
    end
    press(M); press(M | N | U);
    checks++;
    if (mode !== 2'd2 || field !== 2'd0 || time_out !== tv(5, 6, 0) || time_ow !== 1'b0) begin
      errors++; $display("FAIL prio_mode mode=%0d field=%0d time=%h ow=%b expected 2 0 %h 0", mode, field, time_out, time_ow, tv(5, 6, 0));
    end
    press(M); press(U); press(N); press(D); press(N);
    checks++;
    if ({time_ow, date_ow, alarm_set} !== 3'b001 || alarm_out !== {5'd1, 6'd59}) begin
      errors++; $display("FAIL alarm_commit strobes=%b alarm=%h expected 001 %h", {time_ow, date_ow, alarm_set}, alarm_out, {5'd1, 6'd59});
    end
    press(M); press(M); press(M);
    checks++;
    if (mode !== 2'd3 || alarm_out !== {5'd1, 6'd59}) begin
      errors++; $display("FAIL alarm_keep mode=%0d alarm=%h expected 3 %h", mode, alarm_out, {5'd1, 6'd59});
    end
    press(U);
    rst = 1'b1;
    #1;
    checks++;
    if (mode !== 2'd0 || alarm_out !== 11'd0) begin
      errors++; $display("FAIL rst_async mode=%0d alarm=%h expected 0 0", mode, alarm_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= alarm_set;
    end
    checks++;
    if (seen !== 1'b0 || mode !== 2'd0 || alarm_out !== 11'd0) begin
      errors++; $display("FAIL rst_midedit seen=%b mode=%0d alarm=%h expected 0 0 0", seen, mode, alarm_out);
    end
  endtask
  task automatic test_random;
    int ys [5];
    logic [3:0] b;
    logic [16:0] tc;
    logic [20:0] dc;
    int r, mo, y;
    ys = '{0, 1900, 2000, 2023, 2024};
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      checks++;
      if (mode !== 2'(m_mode) || field !== 2'(m_field)) begin
        errors++; $display("FAIL rand_state cyc=%0d mode=%0d field=%0d expected %0d %0d", i, mode, field, m_mode, m_field);
      end
      checks++;
      if ({time_out, date_out, alarm_out, time_ow, date_ow, alarm_set} !==
          {tv(th, tm, 0), dv(dd, dmo, dy), 5'(ah), 6'(am), e_tow, e_dow, e_as}) begin
        errors++; $display("FAIL rand_data cyc=%0d time=%h date=%h alarm=%h str=%b expected %h %h %h %b", i,
                           time_out, date_out, alarm_out, {time_ow, date_ow, alarm_set},
                           tv(th, tm, 0), dv(dd, dmo, dy), {5'(ah), 6'(am)}, {e_tow, e_dow, e_as});
      end
      r = $urandom_range(0, 99);
      if ((i / 400) % 3 == 2) b = r < 3 ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      else b = r < 8 ? M : r < 28 ? N : r < 48 ? U : r < 66 ? D : r < 72 ? 4'($urandom_range(1, 15)) : 4'd0;
      tc = tv($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      mo = $urandom_range(1, 12);
      y = $urandom_range(0, 1) ? $urandom_range(0, 4095) : ys[$urandom_range(0, 4)];
      dc = dv($urandom_range(1, dim_f(mo, y)), mo, y);
      model_edge(b, tc, dc);
      {btn_mode, btn_next, btn_up, btn_down} = b;
      time_cur = tc;
      date_cur = dc;
      @(negedge clk);
    end
    {btn_mode, btn_next, btn_up, btn_down} = 4'd0;
  endtask
  initial begin
    test_reset();
    test_time_edit();
    test_date_clamp();
    test_wraps();
    test_timeout();
    test_priority_and_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
